// File: rtl/data_unpack_stream.sv
// data_unpack_stream: splits a stream of IN_W-bit words into contiguous
// OUT_W-bit packets, LSB-first, across word boundaries.
// Ready/valid on both sides, frame termination via in_last, synchronous flush.
// Optional feature macro: DATA_UNPACK_PAD_EN (emit a zero-padded residual
// packet at frame end instead of discarding the residual bits).
module data_unpack_stream #(
    parameter int IN_W   = 32,
    parameter int OUT_W  = 7,
    parameter int FILL_W = $clog2(IN_W + OUT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             resid_drop
);

    localparam int BUF_W = IN_W + OUT_W - 1;

`ifdef DATA_UNPACK_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam logic [FILL_W-1:0] OUT_STEP = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] IN_STEP  = FILL_W'(IN_W);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t            state;
    logic [BUF_W-1:0]  buf_q;
    logic [FILL_W-1:0] fill;

    logic              full;
    logic              below_two;
    logic              has_resid;
    logic              in_fire;
    logic              out_fire;
    logic [FILL_W-1:0] wr_pos;
    logic [BUF_W-1:0]  buf_next;
    logic [FILL_W-1:0] fill_next;

    // Occupancy decode and handshake outputs, all derived from registers
    // except in_ready, which also looks at out_ready.
    always_comb begin
        full      = int'(fill) >= OUT_W;
        below_two = int'(fill) < 2 * OUT_W;
        has_resid = (fill != '0) && !full;

        out_data  = buf_q[OUT_W-1:0];
        out_valid = 1'b0;
        out_last  = 1'b0;
        resid_drop = 1'b0;
        in_ready  = 1'b0;

        if (state == RUN) begin
            out_valid = full;
            in_ready  = !rst && (!full || (out_ready && below_two));
        end else begin
            if (full) begin
                out_valid = 1'b1;
                out_last  = PAD_EN ? (fill == OUT_STEP) : below_two;
            end else if (PAD_EN && has_resid) begin
                out_valid = 1'b1;
                out_last  = 1'b1;
            end
            resid_drop = !PAD_EN && has_resid;
        end

        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
    end

    // Next buffer contents: pop OUT_W bits and/or append the incoming word
    // just above the bits that remain after the pop.
    always_comb begin
        wr_pos    = out_fire ? (fill - OUT_STEP) : fill;
        buf_next  = out_fire ? (buf_q >> OUT_W) : buf_q;
        fill_next = out_fire ? (fill - OUT_STEP) : fill;
        if (in_fire) begin
            buf_next  = buf_next | (BUF_W'(in_data) << wr_pos);
            fill_next = fill_next + IN_STEP;
        end
    end

    // Frame FSM with buffer and fill counter; flush overrides every handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            buf_q <= '0;
            fill  <= '0;
        end else if (flush) begin
            state <= RUN;
            buf_q <= '0;
            fill  <= '0;
        end else begin
            case (state)
                RUN: begin
                    buf_q <= buf_next;
                    fill  <= fill_next;
                    if (in_fire && in_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Padded build leaves on the residual packet's handshake
                    // (or at once when empty); plain build drops the residual
                    // as soon as less than a full packet remains.
                    if (PAD_EN ? ((fill == '0) || (has_resid && out_fire)) : !full) begin
                        state <= RUN;
                        buf_q <= '0;
                        fill  <= '0;
                    end else begin
                        buf_q <= buf_next;
                        fill  <= fill_next;
                    end
                end
                default: begin
                    state <= RUN;
                    buf_q <= '0;
                    fill  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_unpack_stream.sv
// Directed testbench for data_unpack_stream (IN_W=32, OUT_W=7).
module tb_data_unpack_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [6:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        resid_drop;

    int passed = 0;
    int total  = 0;

    logic [31:0] words [8];
    logic        wlast [8];
    int          gate  [8];
    logic        acc_pop [8];
    int          acc_idx [8];
    logic [6:0]  pkts  [64];
    logic        plast [64];
    int          npk, nin, ndrop, first_v, last_v;
    logic [255:0] stream;
    logic [31:0]  tmp;

    always #5 clk = ~clk;

    data_unpack_stream #(.IN_W(32), .OUT_W(7)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .resid_drop(resid_drop)
    );

    // Streams words[0..nwords-1] with out_ready high; word i is offered once gate[i] packets were taken.
    task automatic run_stream(input int nwords, input int ncyc, input int stop_pops);
        logic acc, pop;
        nin = 0; npk = 0; ndrop = 0; first_v = -1; last_v = -1;
        for (int cyc = 0; cyc < ncyc && npk < stop_pops && npk < 64; cyc++) begin
            in_valid  = (nin < nwords) && (npk >= gate[nin]);
            in_data   = in_valid ? words[nin] : 32'h0;
            in_last   = in_valid && wlast[nin];
            out_ready = 1'b1;
            @(negedge clk);
            acc = in_valid && in_ready;
            pop = out_valid;
            if (resid_drop) ndrop++;
            if (acc) begin
                acc_pop[nin] = pop;
                acc_idx[nin] = npk;
                nin++;
            end
            if (pop) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                pkts[npk]  = out_data;
                plast[npk] = out_last;
                npk++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic clear_words();
        for (int i = 0; i < 8; i++) begin
            words[i] = 32'h0; wlast[i] = 1'b0; gate[i] = 0; acc_pop[i] = 1'b0; acc_idx[i] = -1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        total++;
        if ({out_valid, out_last, resid_drop, in_ready, out_data} !== 11'h0)
            $display("FAIL reset_initial: got v%b l%b d%b r%b data %h want all 0", out_valid, out_last, resid_drop, in_ready, out_data);
        else passed++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        // drive 3 words continuously until 12 packets are taken: fill = 12
        clear_words();
        words[0] = 32'h1111_2222; words[1] = 32'h3333_4444; words[2] = 32'h5555_6666; words[3] = 32'h7777_8888;
        run_stream(4, 40, 12);
        total++;
        if (npk !== 12 || out_valid !== 1'b1)
            $display("FAIL reset_prefill: got pkts %0d valid %b want 12 1", npk, out_valid);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_valid, out_last, resid_drop, in_ready, out_data} !== 11'h0)
            $display("FAIL reset_async: got v%b l%b d%b r%b data %h want all 0", out_valid, out_last, resid_drop, in_ready, out_data);
        else passed++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_release: got ready %b valid %b want 1 0", in_ready, out_valid);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_continuous();
        clear_words();
        words[0] = 32'h7654_3210; words[1] = 32'h89AB_CDEF; words[2] = 32'hDEAD_BEEF; words[3] = 32'h0123_4567;
        words[4] = 32'hCAFE_F00D; words[5] = 32'h1357_9BDF; words[6] = 32'h2468_ACE0;
        stream = '0;
        for (int i = 0; i < 7; i++) stream[32*i +: 32] = words[i];
        do_flush();
        run_stream(7, 80, 64);
        total++;
        if (npk !== 32) $display("FAIL cont_count: got %0d packets want 32", npk); else passed++;
        total++;
        if (last_v - first_v + 1 !== 32)
            $display("FAIL cont_no_bubble: got span %0d cycles want 32", last_v - first_v + 1);
        else passed++;
        total++;
        if (pkts[0] !== 7'h10) $display("FAIL cont_pkt0: got %h want 10", pkts[0]); else passed++;
        total++;
        if (pkts[1] !== 7'h64) $display("FAIL cont_pkt1: got %h want 64", pkts[1]); else passed++;
        for (int k = 0; k < 32; k++) begin
            total++;
            if (pkts[k] !== stream[7*k +: 7] || plast[k] !== 1'b0)
                $display("FAIL cont_pkt%0d: got %h last %b want %h last 0", k, pkts[k], plast[k], stream[7*k +: 7]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] s2;
        int pops, acc_at;
        do_flush();
        s2 = {32'h0F0F_3CC3, 32'hA5C3_1E69};
        in_valid = 1'b1; in_data = 32'hA5C3_1E69; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) $display("FAIL bp_accept: got ready %b want 1", in_ready); else passed++;
        @(posedge clk); #1;
        in_data = 32'h0F0F_3CC3;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== 7'h69 || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d: got v%b d%h r%b want v1 d69 r0", c, out_valid, out_data, in_ready);
            else passed++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        pops = 0; acc_at = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc_at = pops;
            if (out_valid) begin
                total++;
                if (pops >= 9 || out_data !== s2[7*pops +: 7])
                    $display("FAIL bp_pkt%0d: got %h want %h", pops, out_data, (pops < 9) ? s2[7*pops +: 7] : 7'h0);
                else passed++;
                pops++;
            end
            @(posedge clk); #1;
            if (acc_at >= 0) in_valid = 1'b0;
        end
        total++;
        if (pops !== 9 || acc_at !== 3)
            $display("FAIL bp_release: got %0d packets word2 at %0d want 9 at 3", pops, acc_at);
        else passed++;
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        do_flush();
        in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        // fill = 25 here; offer a word and a ready consumer during flush
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) $display("FAIL flush_pre: got valid %b want 1", out_valid); else passed++;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_after: got valid %b ready %b want 0 1", out_valid, in_ready);
        else passed++;
        @(posedge clk); #1;
        tmp = 32'h9C4E_2B75;
        in_valid = 1'b1; in_data = tmp; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== tmp[6:0])
            $display("FAIL flush_pkt0: got v%b %h want v1 %h", out_valid, out_data, tmp[6:0]);
        else passed++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (out_data !== tmp[13:7]) $display("FAIL flush_pkt1: got %h want %h", out_data, tmp[13:7]); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_frame_end();
        clear_words();
        do_flush();
        words[0] = 32'hFFFF_FFFF; wlast[0] = 1'b1;
        run_stream(1, 20, 64);
`ifdef DATA_UNPACK_PAD_EN
        total++;
        if (npk !== 5) $display("FAIL frame_count: got %0d packets want 5", npk); else passed++;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (pkts[k] !== 7'h7F || plast[k] !== 1'b0)
                $display("FAIL frame_pkt%0d: got %h last %b want 7f last 0", k, pkts[k], plast[k]);
            else passed++;
        end
        total++;
        if (pkts[4] !== 7'h0F || plast[4] !== 1'b1)
            $display("FAIL frame_pad: got %h last %b want 0f last 1", pkts[4], plast[4]);
        else passed++;
        total++;
        if (ndrop !== 0) $display("FAIL frame_drop: got %0d pulses want 0", ndrop); else passed++;
`else
        total++;
        if (npk !== 4) $display("FAIL frame_count: got %0d packets want 4", npk); else passed++;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (pkts[k] !== 7'h7F || plast[k] !== (k == 3))
                $display("FAIL frame_pkt%0d: got %h last %b want 7f last %0d", k, pkts[k], plast[k], (k == 3));
            else passed++;
        end
        total++;
        if (ndrop !== 1) $display("FAIL frame_drop: got %0d pulses want 1", ndrop); else passed++;
`endif
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL frame_idle: got valid %b ready %b want 0 1", out_valid, in_ready);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous();
        clear_words();
        words[0] = 32'h0BAD_F00D; words[1] = 32'hFEED_FACE; words[2] = 32'h3141_5926; words[3] = 32'h2718_2818;
        words[4] = 32'h5A5A_5A5A; words[5] = 32'hC0FF_EE11; words[6] = 32'h9E37_79B9;
        // seventh word held back until 26 packets are taken: fill = 10 then
        gate[6] = 26;
        stream = '0;
        for (int i = 0; i < 7; i++) stream[32*i +: 32] = words[i];
        do_flush();
        run_stream(7, 80, 64);
        total++;
        if (acc_pop[6] !== 1'b1 || acc_idx[6] !== 26)
            $display("FAIL sim_fire: got pop %b at %0d want 1 at 26", acc_pop[6], acc_idx[6]);
        else passed++;
        total++;
        if (pkts[27] !== stream[189 +: 7])
            $display("FAIL sim_next: got %h want %h", pkts[27], stream[189 +: 7]);
        else passed++;
        total++;
        if (npk !== 32) $display("FAIL sim_fill35: got %0d packets want 32", npk); else passed++;
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_backpressure();
        test_flush();
        test_frame_end();
        test_simultaneous();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/data_unpack_stream.md
# data_unpack_stream

Parametrised successor to the fixed 32→7 unpacker. Splits a stream of IN_W-bit words into contiguous OUT_W-bit packets, LSB-first, across word boundaries. Adds ready/valid handshakes on both sides, frame termination via `in_last`, and a synchronous flush. It sits between the word-line fetch path and the packet consumer, and replaces the externally sequenced load/count control with an internal fill counter and FSM.

## Interface
- `IN_W`, default 32: input word width. Constraint: `IN_W >= OUT_W`.
- `OUT_W`, default 7: packet width. Constraint: `OUT_W >= 1`.
- `FILL_W`, default `$clog2(IN_W+OUT_W)`: fill counter width. Derived; do not override.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  synchronous clear of buffer, fill counter and FSM
- `in_data`  in  IN_W  input word; bit 0 is the oldest bit
- `in_valid`  in  1  `in_data` and `in_last` are valid
- `in_last`  in  1  current word is the last word of its frame
- `in_ready`  out  1  block accepts the word this cycle
- `out_data`  out  OUT_W  packet; bit 0 is the oldest bit
- `out_valid`  out  1  `out_data` is valid
- `out_last`  out  1  final packet of the frame
- `out_ready`  in  1  consumer takes the packet this cycle
- `resid_drop`  out  1  one-cycle pulse: frame residual discarded

## Operation
- Storage:
  - `buf` is IN_W+OUT_W-1 bits; `fill` is the number of valid bits in it, LSB-aligned.
  - Invariant: bits at index ≥ `fill` are 0.
- Handshakes: `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- Output bus: `out_data = buf[OUT_W-1:0]`.
- Packet pop (`out_fire`): `buf` shifts right by OUT_W, zero-filled, and `fill -= OUT_W`.
- Word push (`in_fire`): `in_data` is written at bit position `fill - OUT_W*out_fire` and `fill += IN_W`. Both pop and push apply in the same cycle when both fire.
- FSM states:
  - **RUN**:
    - `in_ready = (fill < OUT_W) | (out_ready & fill < 2*OUT_W)`.
    - `out_valid = (fill >= OUT_W)`; `out_last = 0`.
    - `in_fire & in_last` → DRAIN.
  - **DRAIN**:
    - `in_ready = 0`.
    - While `fill >= OUT_W`: `out_valid = 1`, and `out_last = 1` iff this packet ends the frame (see Configuration).
    - Once `fill < OUT_W`, residual handling follows Configuration, then → RUN with `fill = 0`.
- Frame length: IN_W ≥ OUT_W guarantees at least one full packet per frame.
- Flush: `flush` has priority over all handshakes. Next state is RUN, `fill = 0`, `buf = 0`. A packet presented in the flush cycle is not consumed and no word is accepted.
- `resid_drop` is always 0 when the pad feature is compiled in.

## Timing
- Reset values (asynchronous, while `rst` is high): FSM = RUN, `fill = 0`, `buf = 0`.
  - Outputs during reset: `out_valid = 0`, `out_last = 0`, `out_data = 0`, `resid_drop = 0`, `in_ready = 0` (gated by `rst`).
- Latency: a word accepted at edge N raises `out_valid` in the cycle after N, when `fill >= OUT_W`.
- Register-driven outputs: `out_valid`, `out_data`, `out_last`, `resid_drop` depend on registers only.
- Combinational path: `in_ready` depends on `out_ready`. This is the only input-to-output path.
- Throughput: with `out_ready` held high, one packet per cycle and no bubbles at word boundaries.
- Output stability: while `out_valid & ~out_ready`, `out_data` and `out_last` are held.
- Overflow rule: `in_ready` never permits `fill` to exceed IN_W+OUT_W-1.

## Configuration
- Macro: `DATA_UNPACK_PAD_EN`.
- Defined:
  - In DRAIN with `0 < fill < OUT_W`, emit one extra packet: residual bits, zero-padded on the MSB side, with `out_valid = 1` and `out_last = 1`. Return to RUN on its `out_fire`.
  - In DRAIN with `fill == 0`, return to RUN directly.
  - A full packet carries `out_last` iff `fill == OUT_W` in DRAIN.
- Undefined:
  - Residual bits are discarded: `fill = 0` and → RUN on the cycle `fill < OUT_W` is reached.
  - `resid_drop` pulses that cycle iff `fill > 0`.
  - A full packet carries `out_last` iff `fill < 2*OUT_W` in DRAIN.

## Test plan
All scenarios use IN_W=32, OUT_W=7.
- **Reset:** assert `rst` mid-stream with `fill = 12` → outputs go to their reset values immediately; after release, `in_ready = 1` and `out_valid = 0`.
- **Continuous stream:** 7 words, first `0x76543210`, `out_ready = 1` → exactly 32 packets and no bubbles; packet 0 = `0x10`, packet 1 = `0x64`; packet k equals stream bits [7k+6:7k].
- **Backpressure:** one word in, `out_ready = 0` for 10 cycles → `out_valid = 1` with `out_data` stable at packet 0; `in_ready = 0` (`fill = 32`); the release sequence is correct.
- **Frame end:** single word `0xFFFFFFFF` with `in_last`.
  - PAD_EN defined → packets `0x7F` ×4, then `0x0F` with `out_last`.
  - PAD_EN undefined → `0x7F` ×4, `out_last` on the 4th packet, `resid_drop` pulses once.
- **Flush:** `flush` asserted mid-frame with `fill = 25` → next cycle `out_valid = 0`, `in_ready = 1`; the next word's packet 0 is its bits [6:0].
- **Simultaneous fire:** `fill = 10`, `in_valid = 1`, `out_ready = 1` → both fire; `fill` becomes 35; the next packet is old bits [13:7].
